// File: rtl/noc_pkg.sv
// ----------------------------------------------------------------------------
// noc_pkg
// Shared types and default sizing for the NoC crossbar.
//   data_t              : 64-bit word carried unmodified from ingress to egress
//   CPU_NB_DEFAULT      : default number of attached cpu ports (power of two, >= 2)
//   FIFO_DEPTH_DEFAULT  : default words buffered per ingress port (>= 2)
// ----------------------------------------------------------------------------
package noc_pkg;

    localparam int DATA_W             = 64;
    localparam int CPU_NB_DEFAULT     = 4;
    localparam int FIFO_DEPTH_DEFAULT = 4;

    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/noc_fifo.sv
// ----------------------------------------------------------------------------
// noc_fifo
// Per-ingress word buffer with an occupancy count of 0..DEPTH.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data this cycle (ignored while full)
//   push_data   : word to buffer
//   pop         : drop the head word this cycle (ignored while empty)
//   full, empty : occupancy flags (full depends only on the stored count)
//   head        : oldest buffered word, valid when !empty
// ----------------------------------------------------------------------------
module noc_fifo
    import noc_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  data_t push_data,
    input  logic  pop,
    output logic  full,
    output logic  empty,
    output data_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    data_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; clearing the pointers and
    // count is enough to discard its contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/noc.sv
// ----------------------------------------------------------------------------
// noc
// CPU_NB x CPU_NB crossbar. Each ingress buffers words in a noc_fifo; the
// low log2(CPU_NB) bits of a head word select its egress port. Each egress
// has one registered output slot and a round-robin pointer that picks among
// the FIFO heads targeting it. Head-of-line blocking is intentional.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   data_cpu_to_noc_vld/rdy : per-cpu ingress handshake (rdy forced 0 in reset)
//   data_cpu_to_noc         : per-cpu ingress words
//   data_noc_to_cpu_vld/rdy : per-cpu egress handshake (vld from flops)
//   data_noc_to_cpu         : per-cpu egress words (from flops)
// ----------------------------------------------------------------------------
module noc
    import noc_pkg::*;
#(
    parameter int CPU_NB     = CPU_NB_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CPU_NB-1:0]   data_cpu_to_noc_vld,
    output logic [CPU_NB-1:0]   data_cpu_to_noc_rdy,
    input  data_t [CPU_NB-1:0]  data_cpu_to_noc,
    output logic [CPU_NB-1:0]   data_noc_to_cpu_vld,
    input  logic [CPU_NB-1:0]   data_noc_to_cpu_rdy,
    output data_t [CPU_NB-1:0]  data_noc_to_cpu
);

    localparam int IDX_W = $clog2(CPU_NB);
    typedef logic [IDX_W-1:0] idx_t;

    logic  [CPU_NB-1:0] full;
    logic  [CPU_NB-1:0] empty;
    logic  [CPU_NB-1:0] push;
    logic  [CPU_NB-1:0] pop;
    logic  [CPU_NB-1:0] free;
    logic  [CPU_NB-1:0] found;
    data_t [CPU_NB-1:0] head;
    idx_t  [CPU_NB-1:0] grant_idx;
    idx_t  [CPU_NB-1:0] rr_ptr;
    logic  [CPU_NB-1:0] egress_vld;
    data_t [CPU_NB-1:0] egress_data;

    for (genvar i = 0; i < CPU_NB; i++) begin : g_ingress
        // Gating with rst_n keeps rdy low while reset is held.
        assign data_cpu_to_noc_rdy[i] = rst_n & ~full[i];
        assign push[i] = data_cpu_to_noc_vld[i] & data_cpu_to_noc_rdy[i];

        noc_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[i]),
            .push_data (data_cpu_to_noc[i]),
            .pop       (pop[i]),
            .full      (full[i]),
            .empty     (empty[i]),
            .head      (head[i])
        );
    end

    assign free = ~egress_vld | data_noc_to_cpu_rdy;

    // Each head has a single destination, so at most one egress can grant a
    // given FIFO and the pops never collide.
    // NOTE: every combinational output gets a default before the loops, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        idx_t idx;
        found     = '0;
        grant_idx = '0;
        pop       = '0;
        idx       = '0;
        for (int j = 0; j < CPU_NB; j++) begin
            for (int k = 0; k < CPU_NB; k++) begin
                // Power-of-two CPU_NB makes the truncating add a modulo wrap.
                idx = rr_ptr[j] + idx_t'(k);
                if (free[j] && !found[j] && !empty[idx] &&
                    head[idx][IDX_W-1:0] == idx_t'(j)) begin
                    found[j]     = 1'b1;
                    grant_idx[j] = idx;
                end
            end
        end
        for (int j = 0; j < CPU_NB; j++) begin
            if (found[j]) pop[grant_idx[j]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            egress_vld  <= '0;
            egress_data <= '0;
            rr_ptr      <= '0;
        end else begin
            for (int j = 0; j < CPU_NB; j++) begin
                if (free[j]) begin
                    egress_vld[j] <= found[j];
                    if (found[j]) begin
                        egress_data[j] <= head[grant_idx[j]];
                        rr_ptr[j]      <= grant_idx[j] + 1'b1;
                    end
                end
            end
        end
    end

    assign data_noc_to_cpu_vld = egress_vld;
    assign data_noc_to_cpu     = egress_data;

endmodule

// File: doc/noc.md
NOC -- requirements
Module: noc

Interface
REQ-001 SHALL have parameter CPU_NB, default 4, meaning the number of attached cpu ports; it SHALL be a power of two and at least 2.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning words buffered per ingress port; it SHALL be at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port data_cpu_to_noc_vld, input, CPU_NB bits: per-cpu ingress valid.
REQ-006 SHALL have port data_cpu_to_noc_rdy, output, CPU_NB bits: per-cpu ingress ready.
REQ-007 SHALL have port data_cpu_to_noc, input, CPU_NB x 64 bits: per-cpu ingress word.
REQ-008 SHALL have port data_noc_to_cpu_vld, output, CPU_NB bits: per-cpu egress valid.
REQ-009 SHALL have port data_noc_to_cpu_rdy, input, CPU_NB bits: per-cpu egress ready.
REQ-010 SHALL have port data_noc_to_cpu, output, CPU_NB x 64 bits: per-cpu egress word.

Function
REQ-011 Transfer SHALL occur on a port only in a cycle where its vld and rdy are both 1 at the rising edge.
REQ-012 Each ingress port SHALL own a FIFO of FIFO_DEPTH words with an occupancy count of 0..FIFO_DEPTH.
REQ-013 data_cpu_to_noc_rdy[i] SHALL be 1 exactly when FIFO i holds fewer than FIFO_DEPTH words; a pop in the same cycle SHALL NOT raise rdy while the FIFO is full.
REQ-014 The destination of a head word SHALL be its bits [log2(CPU_NB)-1:0]; the word SHALL be forwarded unmodified.
REQ-015 Each egress port j SHALL have one output register (vld plus 64-bit data) driving data_noc_to_cpu_vld[j] and data_noc_to_cpu[j] directly from flops.
REQ-016 Egress j SHALL be free when vld[j]=0 or rdy[j]=1; only a free egress SHALL load.
REQ-017 When egress j is free and at least one non-empty FIFO head targets j, exactly one such FIFO SHALL be granted by round-robin: the search starts at rr_ptr[j] and increments modulo CPU_NB.
REQ-018 On a grant, the granted FIFO SHALL be popped, its head word loaded into egress j, vld[j] set to 1, and rr_ptr[j] set to (grant+1) mod CPU_NB.
REQ-019 When egress j is free and no head targets j, vld[j] SHALL become 0 and rr_ptr[j] SHALL hold its value.
REQ-020 Latency: a word accepted at edge k into an empty FIFO with its target egress free and uncontended SHALL be loaded into the egress register at edge k+1 and visible as vld=1 after that edge.
REQ-021 Per (source, destination) pair, order SHALL be preserved; there SHALL be no loss and no duplication.
REQ-022 FIFO heads SHALL be strictly in order; a blocked head SHALL block later words of that FIFO even when they target a different egress (head-of-line blocking is intended).
REQ-023 A simultaneous push and pop on a non-full FIFO SHALL leave the count unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 Egress outputs SHALL remain stable while vld=1 and rdy=0.

Reset
REQ-025 While rst_n=0: all FIFO counts and pointers SHALL be 0, all egress vld 0, egress data 0, every rr_ptr 0, and data_cpu_to_noc_rdy SHALL be forced to 0.
REQ-026 Assertion of rst_n mid-operation SHALL discard all buffered words immediately, without waiting for a clock edge.
REQ-027 At the first edge after rst_n rises, rdy SHALL be all ones.

Structure
REQ-028 Package noc_pkg SHALL hold the 64-bit data_t typedef and the default CPU_NB and FIFO_DEPTH constants.
REQ-029 The ingress buffer SHALL be a sub-module noc_fifo (push, pop, full, empty, head) instantiated CPU_NB times; arbitration and egress registers SHALL stay in noc.

Verification (CPU_NB=4, FIFO_DEPTH=4)
REQ-030 Single word: cpu1 sends 0xdeadbeefdeadbef2 at edge k with all egress rdy=1 -> vld[2]=1 after edge k+1 with identical data; all other egress vld stay 0.
REQ-031 Contention: cpu0, cpu1 and cpu3 each send a word targeting port 2 in the same cycle with rr_ptr[2]=0 -> port 2 emits the cpu0, cpu1, cpu3 words on consecutive cycles; rr_ptr[2] ends at 0.
REQ-032 Backpressure: egress rdy[2]=0 while cpu0 sends 6 words targeting port 2 -> 5 are accepted (1 in the egress register, 4 in the FIFO) and rdy[0] then drops to 0; after rdy[2]=1, all 6 words appear in order.
REQ-033 Full FIFO with pop: FIFO 0 full and popped in the same cycle while vld[0]=1 -> no push that cycle; the word is accepted on the next edge.
REQ-034 Head-of-line: cpu0 head targets blocked port 2 and its next word targets port 1 -> port 1 stays idle until port 2 takes the head.
REQ-035 Reset mid-operation: rst_n pulled low with 3 words buffered -> all egress vld go to 0 at once, rdy goes to 0, and no buffered word appears after rst_n rises.
